// File: rtl/jstk2_led_spi_tx_if.sv
// Colour bus between the colour-setting logic and the JSTK2 LED frame sender.
interface jstk2_led_spi_tx_if;
  logic [23:0] RGBcolor;
  logic        start;
  logic        busy;
  logic        done;

  modport master (
    output RGBcolor,
    output start,
    input  busy,
    input  done
  );

  modport slave (
    input  RGBcolor,
    input  start,
    output busy,
    output done
  );
endinterface

// File: rtl/jstk2_led_spi_tx.sv
// SPI master sending the JSTK2 "set LED" frame: CMD_BYTE, R, G, B, 8'h00.
module jstk2_led_spi_tx #(
  parameter int unsigned CLK_DIV  = 6,
  parameter int unsigned SS_SETUP = 300,
  parameter int unsigned BYTE_GAP = 120,
  parameter int unsigned SS_HOLD  = 300,
  parameter logic [7:0]  CMD_BYTE = 8'h84
) (
  input  logic              clk,
  input  logic              rst,
  jstk2_led_spi_tx_if.slave cbus,
  output logic              ss_n,
  output logic              sclk,
  output logic              mosi
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

  localparam logic [31:0] DIV_LAST   = 32'(CLK_DIV - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SS_SETUP - 1);
  localparam logic [31:0] GAP_LAST   = 32'(BYTE_GAP - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(SS_HOLD - 1);

  state_t      state_q, state_nxt;
  logic [31:0] cnt_q, cnt_nxt;
  logic [31:0] div_q, div_nxt;
  logic        ph_q, ph_nxt;
  logic [2:0]  bit_q, bit_nxt;
  logic [2:0]  byte_q, byte_nxt;
  logic [39:0] frame_q, frame_nxt;

  logic ss_n_q, sclk_q, mosi_q, busy_q, done_q;
  logic ss_n_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      ph_q    <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      div_q   <= div_nxt;
      ph_q    <= ph_nxt;
      bit_q   <= bit_nxt;
      byte_q  <= byte_nxt;
      frame_q <= frame_nxt;
      ss_n_q  <= ss_n_nxt;
      sclk_q  <= sclk_nxt;
      mosi_q  <= mosi_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // frame_q shifts left once per finished bit, so its MSB is always the next bit to send
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    div_nxt   = div_q;
    ph_nxt    = ph_q;
    bit_nxt   = bit_q;
    byte_nxt  = byte_q;
    frame_nxt = frame_q;
    unique case (state_q)
      IDLE: begin
        // done_q marks the completion cycle; a start seen there is dropped
        if (cbus.start && !done_q) begin
          state_nxt = SETUP;
          frame_nxt = {CMD_BYTE, cbus.RGBcolor, 8'h00};
          byte_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          div_nxt   = '0;
          ph_nxt    = 1'b0;
          bit_nxt   = 3'd7;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_nxt = '0;
          if (!ph_q) begin
            ph_nxt = 1'b1;
          end else begin
            ph_nxt    = 1'b0;
            frame_nxt = {frame_q[38:0], 1'b0};
            if (bit_q == 3'd0) begin
              cnt_nxt = '0;
              if (byte_q < 3'd4) begin
                byte_nxt  = byte_q + 3'd1;
                state_nxt = GAP;
              end else begin
                state_nxt = HOLD;
              end
            end else begin
              bit_nxt = bit_q - 3'd1;
            end
          end
        end else begin
          div_nxt = div_q + 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          div_nxt   = '0;
          ph_nxt    = 1'b0;
          bit_nxt   = 3'd7;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it
  always_comb begin
    ss_n_nxt = (state_nxt == IDLE);
    busy_nxt = (state_nxt != IDLE);
    sclk_nxt = (state_nxt == SHIFT) && ph_nxt;
    mosi_nxt = (state_nxt == SHIFT) && frame_nxt[39];
    done_nxt = (state_q == HOLD) && (cnt_q == HOLD_LAST);
  end

  assign ss_n      = ss_n_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cbus.busy = busy_q;
  assign cbus.done = done_q;

endmodule

// File: tb/tb_jstk2_led_spi_tx.sv
// Directed bench for jstk2_led_spi_tx: default and compact-timing instances with an SPI slave monitor.
module tb_jstk2_led_spi_tx;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  jstk2_led_spi_tx_if bus0 ();
  jstk2_led_spi_tx_if bus1 ();

  logic [1:0] ss_n_v, sclk_v, mosi_v, done_v, busy_v;

  jstk2_led_spi_tx u_def (
    .clk  (clk),
    .rst  (rst0),
    .cbus (bus0),
    .ss_n (ss_n_v[0]),
    .sclk (sclk_v[0]),
    .mosi (mosi_v[0])
  );

  jstk2_led_spi_tx #(
    .CLK_DIV  (2),
    .SS_SETUP (4),
    .BYTE_GAP (3),
    .SS_HOLD  (4)
  ) u_small (
    .clk  (clk),
    .rst  (rst1),
    .cbus (bus1),
    .ss_n (ss_n_v[1]),
    .sclk (sclk_v[1]),
    .mosi (mosi_v[1])
  );

  assign done_v = {bus1.done, bus0.done};
  assign busy_v = {bus1.busy, bus0.busy};

  int total = 0;
  int bad   = 0;

  int unsigned lowcnt[2]    = '{0, 0};
  int unsigned highcnt[2]   = '{0, 0};
  int unsigned last_len[2]  = '{0, 0};
  int unsigned last_high[2] = '{0, 0};
  int unsigned nbits[2]     = '{0, 0};
  int unsigned last_bits[2] = '{0, 0};
  int unsigned dones[2]     = '{0, 0};
  int unsigned unstable[2]  = '{0, 0};
  int unsigned viol[2]      = '{0, 0};
  logic [39:0] cap[2]       = '{40'h0, 40'h0};
  logic [39:0] last_cap[2]  = '{40'h0, 40'h0};
  logic [1:0]  prev_ssn  = 2'b11;
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_mosi = 2'b00;

  // Slave-side view of the bus, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_ssn[i] && !ss_n_v[i]) begin
        last_high[i] = highcnt[i];
        highcnt[i]   = 0;
        lowcnt[i]    = 0;
        nbits[i]     = 0;
        cap[i]       = '0;
      end
      if (!ss_n_v[i]) lowcnt[i]++;
      else            highcnt[i]++;
      if (!prev_ssn[i] && ss_n_v[i]) begin
        last_len[i]  = lowcnt[i];
        last_cap[i]  = cap[i];
        last_bits[i] = nbits[i];
      end
      if (!prev_sclk[i] && sclk_v[i]) begin
        cap[i] = {cap[i][38:0], mosi_v[i]};
        nbits[i]++;
        if (mosi_v[i] !== prev_mosi[i]) unstable[i]++;
      end
      if (prev_sclk[i] && sclk_v[i] && (mosi_v[i] !== prev_mosi[i])) unstable[i]++;
      if (ss_n_v[i] && sclk_v[i]) viol[i]++;
      if (done_v[i]) dones[i]++;
      prev_ssn[i]  = ss_n_v[i];
      prev_sclk[i] = sclk_v[i];
      prev_mosi[i] = mosi_v[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int i, input logic v);
    if (i == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  task automatic set_rgb(input int i, input logic [23:0] v);
    if (i == 0) bus0.RGBcolor = v;
    else        bus1.RGBcolor = v;
  endtask

  task automatic pulse(input int i);
    set_start(i, 1'b1);
    tick;
    set_start(i, 1'b0);
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int n = 0; n < budget && !done_v[i]; n++) tick;
    chk("done_seen", 64'(done_v[i]), 64'h1);
  endtask

  // Checks the frame just closed; call one tick after the done cycle began
  task automatic frame_chk(input int i, input logic [39:0] exp_cap, input int unsigned exp_len);
    chk("frame_bytes", 64'(last_cap[i]), 64'(exp_cap));
    chk("frame_len", 64'(last_len[i]), 64'(exp_len));
    chk("frame_bits", 64'(last_bits[i]), 64'd40);
  endtask

  int unsigned d0;

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus0.RGBcolor = '0;
    bus1.RGBcolor = '0;
    tick;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ss_n", 64'(ss_n_v[i]), 64'h1);
      chk("rst_sclk", 64'(sclk_v[i]), 64'h0);
      chk("rst_mosi", 64'(mosi_v[i]), 64'h0);
      chk("rst_busy", 64'(busy_v[i]), 64'h0);
      chk("rst_done", 64'(done_v[i]), 64'h0);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick;

    // Default timing: 300 + 480 + 480 + 300 cycles with ss_n low
    set_rgb(0, 24'h7F0000);
    pulse(0);
    chk("def_busy_after_start", 64'(busy_v[0]), 64'h1);
    chk("def_ss_n_after_start", 64'(ss_n_v[0]), 64'h0);
    wait_done(0, 2500);
    tick;
    frame_chk(0, 40'h847F000000, 1560);
    chk("def_dones", 64'(dones[0]), 64'h1);
    chk("def_done_one_cycle", 64'(done_v[0]), 64'h0);
    chk("def_mosi_stable", 64'(unstable[0]), 64'h0);

    // Compact timing: 4 + 160 + 12 + 4 cycles
    set_rgb(1, 24'h7F7F7F);
    d0 = dones[1];
    pulse(1);
    chk("sm_busy_after_start", 64'(busy_v[1]), 64'h1);
    chk("sm_ss_n_after_start", 64'(ss_n_v[1]), 64'h0);
    wait_done(1, 400);
    chk("sm_ss_n_on_done", 64'(ss_n_v[1]), 64'h1);
    chk("sm_busy_on_done", 64'(busy_v[1]), 64'h0);
    tick;
    frame_chk(1, 40'h847F7F7F00, 180);
    chk("sm_dones", 64'(dones[1] - d0), 64'h1);
    chk("sm_done_one_cycle", 64'(done_v[1]), 64'h0);

    // Start held high: back-to-back frames, no corruption
    set_rgb(1, 24'h00007F);
    set_start(1, 1'b1);
    for (int f = 0; f < 3; f++) begin
      wait_done(1, 400);
      if (f == 2) set_start(1, 1'b0);
      tick;
      frame_chk(1, 40'h8400007F00, 180);
      if (f > 0) chk("rep_ss_n_gap", 64'(last_high[1] >= 1), 64'h1);
    end
    tick;
    chk("rep_idle_after_release", 64'(busy_v[1]), 64'h0);

    // Colour changes during byte 1 must not leak into the latched frame
    set_rgb(1, 24'h007F00);
    pulse(1);
    repeat (45) tick;
    set_rgb(1, 24'hFFFFFF);
    wait_done(1, 400);
    tick;
    frame_chk(1, 40'h84007F0000, 180);
    pulse(1);
    wait_done(1, 400);
    tick;
    frame_chk(1, 40'h84FFFFFF00, 180);

    // Asynchronous reset inside byte 2 aborts with no done pulse
    set_rgb(1, 24'h7F7F7F);
    pulse(1);
    repeat (85) tick;
    chk("abort_busy_before", 64'(busy_v[1]), 64'h1);
    d0 = dones[1];
    #1 rst1 = 1'b1;
    #1;
    chk("abort_ss_n", 64'(ss_n_v[1]), 64'h1);
    chk("abort_sclk", 64'(sclk_v[1]), 64'h0);
    chk("abort_mosi", 64'(mosi_v[1]), 64'h0);
    chk("abort_busy", 64'(busy_v[1]), 64'h0);
    tick;
    tick;
    rst1 = 1'b0;
    tick;
    tick;
    chk("abort_no_done", 64'(dones[1] - d0), 64'h0);
    chk("abort_stays_idle", 64'(busy_v[1]), 64'h0);
    pulse(1);
    wait_done(1, 400);
    tick;
    frame_chk(1, 40'h847F7F7F00, 180);

    // Start on the done cycle is dropped
    set_rgb(1, 24'h123456);
    pulse(1);
    wait_done(1, 400);
    set_start(1, 1'b1);
    tick;
    set_start(1, 1'b0);
    chk("done_start_busy", 64'(busy_v[1]), 64'h0);
    chk("done_start_ss_n", 64'(ss_n_v[1]), 64'h1);
    tick;
    chk("done_start_still_idle", 64'(busy_v[1]), 64'h0);
    frame_chk(1, 40'h8412345600, 180);

    // Start on the cycle after done is accepted
    pulse(1);
    wait_done(1, 400);
    tick;
    set_start(1, 1'b1);
    tick;
    set_start(1, 1'b0);
    chk("after_done_busy", 64'(busy_v[1]), 64'h1);
    chk("after_done_ss_n", 64'(ss_n_v[1]), 64'h0);
    wait_done(1, 400);
    tick;
    frame_chk(1, 40'h8412345600, 180);

    chk("sm_mosi_stable", 64'(unstable[1]), 64'h0);
    chk("sm_no_sclk_idle", 64'(viol[1]), 64'h0);
    chk("def_no_sclk_idle", 64'(viol[0]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
